// File: rtl/owner_restock_bank.sv
// owner_restock_bank: per-slot stock counters with an owner charge path
// (valid/ready, fixed three-cycle commit) and a customer dispense path.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   charge_valid/_slot/_amount, charge_ready, charge_done   owner charge handshake
//   red_light             sticky overflow / bad-slot alarm
//   dispense_req/_slot, dispense_ready, dispense_ok/_fail   customer dispense
//   supply_out            flattened stock, slot i at [i*CNT_W +: CNT_W]
//   empty_mask            bit i set when slot i is empty
module owner_restock_bank #(
   parameter int unsigned NUM_SLOTS   = 4,
   parameter int unsigned SLOT_W      = 2,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned CAPACITY    = 15,
   parameter int unsigned MODE        = 0,
   parameter int unsigned INIT_SUPPLY = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       charge_valid,
   input  logic [SLOT_W-1:0]          charge_slot,
   input  logic [CNT_W-1:0]           charge_amount,
   output logic                       charge_ready,
   output logic                       charge_done,
   output logic                       red_light,
   input  logic                       dispense_req,
   input  logic [SLOT_W-1:0]          dispense_slot,
   output logic                       dispense_ready,
   output logic                       dispense_ok,
   output logic                       dispense_fail,
   output logic [NUM_SLOTS*CNT_W-1:0] supply_out,
   output logic [NUM_SLOTS-1:0]       empty_mask
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_stock [NUM_SLOTS];
   logic [SLOT_W-1:0]  r_slot;
   logic [CNT_W-1:0]   r_amount;
   logic [CNT_W:0]     r_sum;
   logic               r_ovf;
   logic               r_bad;

   logic [CNT_W-1:0]   w_chg_cur;
   logic               w_chg_in;
   logic [CNT_W-1:0]   w_dsp_cur;
   logic               w_dsp_in;
   logic [CNT_W:0]     w_sum;
   logic               w_chg_take;
   logic               w_dsp_take;
   logic               w_ovf_any;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and handshake readies
   always_comb begin
      w_state_nxt    = r_state;
      charge_ready   = 1'b0;
      dispense_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            charge_ready   = 1'b1;
            dispense_ready = !charge_valid;
            if (charge_valid) w_state_nxt = S_CALC;
         end
         S_CALC:   w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Slot lookups; an index past NUM_SLOTS matches nothing and reads as zero
   always_comb begin
      w_chg_cur = '0;
      w_chg_in  = 1'b0;
      w_dsp_cur = '0;
      w_dsp_in  = 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         if (r_slot == SLOT_W'(i)) begin
            w_chg_in  = 1'b1;
            w_chg_cur = r_stock[i];
         end
         if (dispense_slot == SLOT_W'(i)) begin
            w_dsp_in  = 1'b1;
            w_dsp_cur = r_stock[i];
         end
      end
   end

   assign w_sum      = (CNT_W+1)'(w_chg_cur) + (CNT_W+1)'(r_amount);
   assign w_chg_take = charge_valid && charge_ready;
   assign w_dsp_take = dispense_req && dispense_ready;
   // The carry bit always implies overflow since CAPACITY fits in CNT_W bits
   assign w_ovf_any  = r_ovf || r_sum[CNT_W];

   // Datapath: charge pipeline registers, stock array, alarm and pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) r_stock[i] <= CNT_W'(INIT_SUPPLY);
         r_slot        <= '0;
         r_amount      <= '0;
         r_sum         <= '0;
         r_ovf         <= 1'b0;
         r_bad         <= 1'b0;
         red_light     <= 1'b0;
         charge_done   <= 1'b0;
         dispense_ok   <= 1'b0;
         dispense_fail <= 1'b0;
      end else begin
         charge_done   <= 1'b0;
         dispense_ok   <= 1'b0;
         dispense_fail <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_chg_take) begin
                  r_slot   <= charge_slot;
                  r_amount <= charge_amount;
               end else if (w_dsp_take) begin
                  if (w_dsp_in && (w_dsp_cur != '0)) begin
                     for (int i = 0; i < int'(NUM_SLOTS); i++)
                        if (dispense_slot == SLOT_W'(i)) r_stock[i] <= r_stock[i] - CNT_W'(1);
                     dispense_ok <= 1'b1;
                  end else begin
                     dispense_fail <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               r_sum <= w_sum;
               r_ovf <= (w_sum > (CNT_W+1)'(CAPACITY));
               r_bad <= !w_chg_in;
            end
            S_COMMIT: begin
               charge_done <= 1'b1;
               if (r_bad) begin
                  red_light <= 1'b1;
               end else if (w_ovf_any) begin
                  red_light <= 1'b1;
                  if (MODE == 0) begin
                     for (int i = 0; i < int'(NUM_SLOTS); i++)
                        if (r_slot == SLOT_W'(i)) r_stock[i] <= CNT_W'(CAPACITY);
                  end
               end else begin
                  red_light <= 1'b0;
                  for (int i = 0; i < int'(NUM_SLOTS); i++)
                     if (r_slot == SLOT_W'(i)) r_stock[i] <= r_sum[CNT_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   // Flattened stock view and empty flags
   always_comb begin
      supply_out = '0;
      empty_mask = '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         supply_out[i*CNT_W +: CNT_W] = r_stock[i];
         empty_mask[i]                = (r_stock[i] == '0);
      end
   end

endmodule

// File: tb/tb_owner_restock_bank.sv
// Bench for owner_restock_bank: two instances (saturate / reject with a
// three-slot, reduced-capacity bank) driven by the same stimulus and compared
// every cycle against a transaction-level model.
module tb_owner_restock_bank;

   logic        clk;
   logic        rst;
   logic        charge_valid;
   logic [1:0]  charge_slot;
   logic [3:0]  charge_amount;
   logic        dispense_req;
   logic [1:0]  dispense_slot;

   logic        a_charge_ready, a_charge_done, a_red_light;
   logic        a_dispense_ready, a_dispense_ok, a_dispense_fail;
   logic [15:0] a_supply_out;
   logic [3:0]  a_empty_mask;

   logic        b_charge_ready, b_charge_done, b_red_light;
   logic        b_dispense_ready, b_dispense_ok, b_dispense_fail;
   logic [11:0] b_supply_out;
   logic [2:0]  b_empty_mask;

   int n_tests = 0;
   int n_fail  = 0;

   owner_restock_bank #(
      .NUM_SLOTS(4), .SLOT_W(2), .CNT_W(4), .CAPACITY(15), .MODE(0), .INIT_SUPPLY(0)
   ) u_a (
      .clk(clk), .rst(rst),
      .charge_valid(charge_valid), .charge_slot(charge_slot), .charge_amount(charge_amount),
      .charge_ready(a_charge_ready), .charge_done(a_charge_done), .red_light(a_red_light),
      .dispense_req(dispense_req), .dispense_slot(dispense_slot),
      .dispense_ready(a_dispense_ready), .dispense_ok(a_dispense_ok), .dispense_fail(a_dispense_fail),
      .supply_out(a_supply_out), .empty_mask(a_empty_mask)
   );

   owner_restock_bank #(
      .NUM_SLOTS(3), .SLOT_W(2), .CNT_W(4), .CAPACITY(12), .MODE(1), .INIT_SUPPLY(2)
   ) u_b (
      .clk(clk), .rst(rst),
      .charge_valid(charge_valid), .charge_slot(charge_slot), .charge_amount(charge_amount),
      .charge_ready(b_charge_ready), .charge_done(b_charge_done), .red_light(b_red_light),
      .dispense_req(dispense_req), .dispense_slot(dispense_slot),
      .dispense_ready(b_dispense_ready), .dispense_ok(b_dispense_ok), .dispense_fail(b_dispense_fail),
      .supply_out(b_supply_out), .empty_mask(b_empty_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per-instance configuration and state
   int m_ns   [2] = '{4, 3};
   int m_cap  [2] = '{15, 12};
   int m_mode [2] = '{0, 1};
   int m_init [2] = '{0, 2};
   int m_stock[2][4];
   int m_busy [2];     // cycles left before the pending charge commits
   int m_slot [2];
   int m_amt  [2];
   bit m_red  [2];
   bit m_done [2];
   bit m_ok   [2];
   bit m_fail [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      for (int i = 0; i < 4; i++) m_stock[k][i] = m_init[k];
      m_busy[k] = 0;
      m_red[k]  = 1'b0;
      m_done[k] = 1'b0;
      m_ok[k]   = 1'b0;
      m_fail[k] = 1'b0;
   endtask

   // One clock edge's worth of behaviour, using the inputs held across it
   task automatic model_edge(input int k);
      int s;
      if (rst) begin
         model_reset(k);
      end else begin
         m_done[k] = 1'b0;
         m_ok[k]   = 1'b0;
         m_fail[k] = 1'b0;
         if (m_busy[k] == 0) begin
            if (charge_valid) begin
               m_slot[k] = int'(charge_slot);
               m_amt[k]  = int'(charge_amount);
               m_busy[k] = 2;
            end else if (dispense_req) begin
               if (int'(dispense_slot) < m_ns[k] && m_stock[k][dispense_slot] > 0) begin
                  m_stock[k][dispense_slot]--;
                  m_ok[k] = 1'b1;
               end else begin
                  m_fail[k] = 1'b1;
               end
            end
         end else if (m_busy[k] == 2) begin
            m_busy[k] = 1;
         end else begin
            m_busy[k] = 0;
            m_done[k] = 1'b1;
            if (m_slot[k] >= m_ns[k]) begin
               m_red[k] = 1'b1;
            end else begin
               s = m_stock[k][m_slot[k]] + m_amt[k];
               if (s > m_cap[k]) begin
                  m_red[k] = 1'b1;
                  if (m_mode[k] == 0) m_stock[k][m_slot[k]] = m_cap[k];
               end else begin
                  m_stock[k][m_slot[k]] = s;
                  m_red[k] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic check_ready(input int k, input logic cr, input logic dr);
      string p;
      p = (k == 0) ? "a_" : "b_";
      chk({p, "charge_ready"}, 32'(cr), 32'(m_busy[k] == 0));
      chk({p, "dispense_ready"}, 32'(dr), 32'(m_busy[k] == 0 && !charge_valid));
   endtask

   task automatic check_inst(input int k, input logic cd, input logic rl, input logic ok,
                             input logic fl, input logic [15:0] sup, input logic [3:0] emp);
      string       p;
      logic [15:0] es;
      logic [3:0]  ee;
      p  = (k == 0) ? "a_" : "b_";
      es = '0;
      ee = '0;
      for (int i = 0; i < m_ns[k]; i++) begin
         es[i*4 +: 4] = 4'(m_stock[k][i]);
         ee[i]        = (m_stock[k][i] == 0);
      end
      chk({p, "charge_done"},   32'(cd),  32'(m_done[k]));
      chk({p, "red_light"},     32'(rl),  32'(m_red[k]));
      chk({p, "dispense_ok"},   32'(ok),  32'(m_ok[k]));
      chk({p, "dispense_fail"}, 32'(fl),  32'(m_fail[k]));
      chk({p, "supply_out"},    32'(sup), 32'(es));
      chk({p, "empty_mask"},    32'(emp), 32'(ee));
   endtask

   task automatic check_all();
      check_inst(0, a_charge_done, a_red_light, a_dispense_ok, a_dispense_fail,
                 a_supply_out, a_empty_mask);
      check_inst(1, b_charge_done, b_red_light, b_dispense_ok, b_dispense_fail,
                 {4'b0, b_supply_out}, {1'b0, b_empty_mask});
   endtask

   // Drive one cycle: readies checked before the edge, everything else after
   task automatic step(input bit cv, input bit [1:0] cs, input bit [3:0] ca,
                       input bit dr, input bit [1:0] ds, input bit r);
      charge_valid  = cv;
      charge_slot   = cs;
      charge_amount = ca;
      dispense_req  = dr;
      dispense_slot = ds;
      rst           = r;
      #1;
      check_ready(0, a_charge_ready, a_dispense_ready);
      check_ready(1, b_charge_ready, b_dispense_ready);
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0);
   endtask

   // Accept a charge, with the slot/amount inputs scrambled after the accept
   task automatic charge(input bit [1:0] s, input bit [3:0] a);
      step(1'b1, s, a, 1'b0, 2'd0, 1'b0);
      step(1'b0, ~s, ~a, 1'b0, 2'd0, 1'b0);
      step(1'b0, s ^ 2'd1, a + 4'd3, 1'b0, 2'd0, 1'b0);
   endtask

   initial begin
      rst           = 1'b1;
      charge_valid  = 1'b0;
      charge_slot   = '0;
      charge_amount = '0;
      dispense_req  = 1'b0;
      dispense_slot = '0;
      repeat (2) @(posedge clk);
      model_reset(0);
      model_reset(1);
      #1;
      check_all();

      // Basic charges, saturate/reject, clean zero-amount commit
      charge(2'd0, 4'd7);  idle();
      charge(2'd0, 4'd5);  idle();
      charge(2'd0, 4'd5);  idle();
      charge(2'd1, 4'd0);  idle();
      // Slot 3 is out of range for the three-slot instance
      charge(2'd3, 4'd4);  idle();
      charge(2'd1, 4'd0);
      charge(2'd2, 4'd1);  idle();
      // Back-to-back dispenses from slot 2
      step(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b0);
      step(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b0);
      step(1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 1'b0);
      idle();
      // Charge and dispense in the same cycle: dispense held until IDLE
      step(1'b1, 2'd1, 4'd3, 1'b1, 2'd0, 1'b0);
      step(1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 1'b0);
      step(1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 1'b0);
      step(1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 1'b0);
      idle();
      // Reset while the charge sits in COMMIT
      step(1'b1, 2'd1, 4'd5, 1'b0, 2'd0, 1'b0);
      step(1'b0, 2'd1, 4'd5, 1'b0, 2'd0, 1'b0);
      step(1'b0, 2'd1, 4'd5, 1'b0, 2'd0, 1'b1);
      idle();
      idle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 63) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/owner_restock_bank.md
# owner_restock_bank

Parametrised multi-slot owner restock controller for the vending machine. Holds one stock counter per product slot. Accepts owner charge requests through a valid/ready handshake and commits them with a fixed three-cycle latency. Overflow is handled by a selectable saturate-or-reject policy with a red-light alarm, and a customer dispense path decrements stock in the same block.

## Interface
- NUM_SLOTS, default 4: number of product slots (2..16).
- SLOT_W, default 2: slot index width, ceil(log2(NUM_SLOTS)).
- CNT_W, default 4: stock counter and charge amount width.
- CAPACITY, default 15: max stock per slot, ≤ 2^CNT_W − 1.
- MODE, default 0: overflow policy; 0 = saturate to CAPACITY, 1 = reject (stock unchanged).
- INIT_SUPPLY, default 0: per-slot stock after reset, ≤ CAPACITY.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- charge_valid  in  1  owner charge request.
- charge_slot  in  SLOT_W  target slot.
- charge_amount  in  CNT_W  units to add.
- charge_ready  out  1  block can accept a charge.
- charge_done  out  1  one-cycle pulse when a charge commits (success, saturate, reject or bad slot).
- red_light  out  1  overflow / bad-slot alarm.
- dispense_req  in  1  customer dispense request.
- dispense_slot  in  SLOT_W  slot to dispense from.
- dispense_ready  out  1  dispense request is sampled this cycle.
- dispense_ok  out  1  one-cycle pulse: unit dispensed.
- dispense_fail  out  1  one-cycle pulse: slot empty or out of range.
- supply_out  out  NUM_SLOTS*CNT_W  flattened stock, slot i at bits [i*CNT_W +: CNT_W].
- empty_mask  out  NUM_SLOTS  bit i high when slot i stock == 0.

## Operation
- FSM states: IDLE, CALC, COMMIT.
- Registers: slot, amount, CNT_W+1-bit sum, overflow flag, bad-slot flag.
- IDLE:
  - charge_ready = 1.
  - On charge_valid, latch slot and amount, then go to CALC.
- CALC:
  - sum = supply[slot] + amount, computed at CNT_W+1 bits (no wrap).
  - overflow = sum > CAPACITY.
  - bad = slot ≥ NUM_SLOTS.
  - Go to COMMIT.
- COMMIT:
  - If bad: stock unchanged, red_light = 1.
  - Else if overflow: MODE 0 writes CAPACITY, MODE 1 leaves stock unchanged; red_light = 1 in both modes.
  - Else: write sum[CNT_W-1:0] and clear red_light.
  - amount == 0 is a legal no-op commit and clears red_light.
  - Pulse charge_done, then return to IDLE.
- red_light is sticky. It is held until the next clean commit or rst.
- Dispense path:
  - dispense_ready = (state == IDLE) && !charge_valid. Charge has priority, and no dispense is taken during CALC or COMMIT, so stock never sees two writes in one cycle.
  - When dispense_req && dispense_ready at an edge: if slot is in range and stock > 0, decrement stock and pulse dispense_ok; otherwise leave stock unchanged and pulse dispense_fail.
  - A dispense request while dispense_ready is low is ignored; the requester holds it.
- empty_mask and supply_out are driven combinationally from the stock registers.

## Timing
- Reset values:
  - state = IDLE.
  - Every slot = INIT_SUPPLY.
  - red_light, charge_done, dispense_ok, dispense_fail = 0.
  - charge_ready = 1 and dispense_ready = 1 in the first cycle after reset.
- Charge accepted at edge E0 (charge_valid & charge_ready):
  - CALC during E0..E1; COMMIT during E1..E2.
  - Stock, red_light and charge_done are updated at edge E2.
  - charge_done is high for exactly the cycle E2..E3.
  - charge_ready is low from E0 to E2 and high again after E2.
  - Peak throughput is one charge per 3 cycles.
- charge_slot and charge_amount are sampled only at E0 and may change afterwards.
- A dispense accepted at edge E updates stock at E. dispense_ok or dispense_fail is high for the cycle E..E+1.
- Back-to-back dispenses are allowed every cycle while in IDLE with no charge_valid.
- rst mid-charge (in CALC or COMMIT) aborts the charge:
  - No commit and no charge_done.
  - All stock returns to INIT_SUPPLY.
- Stock never exceeds CAPACITY and never goes below 0.

## Test plan
- Reset, then charge slot 0 with 7, then charge slot 0 with 5 → supply slot0 = 7, then 12. charge_done pulses 3 cycles after each accept. red_light stays 0.
- MODE 0, slot 0 = 12, charge 5 → slot0 = 15 and red_light = 1. A following charge of 0 on slot 1 clears red_light. MODE 1 with the same stimulus → slot0 stays 12 and red_light = 1.
- NUM_SLOTS = 3, SLOT_W = 2, charge slot 3 with 4 → no stock changes, red_light = 1, charge_done pulses.
- Slot 2 = 1, dispense slot 2 twice on consecutive cycles → first gives dispense_ok and slot2 = 0 with empty_mask[2] = 1; second gives dispense_fail.
- charge_valid and dispense_req high in the same IDLE cycle → charge accepted, dispense_ready = 0, dispense held. The dispense is taken in the first IDLE cycle after charge_done with charge_valid low.
- Assert rst during COMMIT of a charge of 5 to slot 1 → no charge_done, all slots = INIT_SUPPLY, charge_ready = 1 in the next cycle.
